sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO; successor to the fixed 8x32 buffer.
//   Configurable width, depth, almost-full/almost-empty thresholds and read mode:
//   registered read or first-word-fall-through (FWFT).
//   Adds an occupancy count and sticky overflow/underflow error flags.
//   Sits between the stimulus/producer path and downstream consumers in the datapath.
// PARAMETERS
//   DATA_W     32        data word width in bits (>=1)
//   DEPTH      8         number of entries; power of 2, >=2
//   AF_THRESH  DEPTH-2   almost_full asserted when count >= AF_THRESH
//   AE_THRESH  2         almost_empty asserted when count <= AE_THRESH
//   FWFT       0         0 = registered read, 1 = first-word-fall-through
// PORTS
//   clk           in   1                   clock, all logic on rising edge
//   rst           in   1                   synchronous, active-high reset
//   wr_en         in   1                   write request
//   wr_data       in   DATA_W              write data
//   rd_en         in   1                   read/pop request
//   rd_data       out  DATA_W              read data
//   rd_valid      out  1                   rd_data holds a valid word
//   full          out  1                   count == DEPTH (active-high)
//   empty         out  1                   count == 0 (active-high)
//   almost_full   out  1                   count >= AF_THRESH
//   almost_empty  out  1                   count <= AE_THRESH
//   count         out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
//   overflow      out  1                   sticky: write attempted while full
//   underflow     out  1                   sticky: read attempted while empty
//   clr_err       in   1                   clears overflow/underflow next edge
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//   - Pointers and count go to 0.
//   - empty=1, almost_empty=1; full=0, almost_full=0.
//   - rd_valid=0, rd_data=0, overflow=0, underflow=0.
//   - Array contents are not cleared.
//   - Reset mid-operation discards all stored data; in-flight requests that cycle are ignored.
//   Pointers:
//   - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - count is a separate register: +1 on write-only, -1 on read-only, unchanged on both.
//   Acceptance:
//   - wr_acc = wr_en & ~full.
//   - rd_acc = rd_en & ~empty.
//   - Both are evaluated on pre-edge state.
//   Simultaneous events:
//   - Full with wr_en & rd_en: only the read is accepted; overflow is set.
//   - Empty with wr_en & rd_en: only the write is accepted; underflow is set.
//   - Otherwise both are accepted and count is unchanged.
//   Flags:
//   - empty, full, almost_* are decoded from the count register.
//   - They reflect post-edge state with no extra latency.
//   Errors:
//   - overflow <= 1 when wr_en & full; underflow <= 1 when rd_en & empty.
//   - Flags stay set until clr_err or rst.
//   - If clr_err coincides with a new error, the set wins.
//   FWFT=0 (registered read):
//   - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge (1-cycle latency).
//   - rd_valid is 0 in cycles without rd_acc; rd_data holds its last value.
//   FWFT=1 (first-word-fall-through):
//   - rd_data = mem[rd_ptr] and rd_valid = ~empty (combinational from state).
//   - rd_en pops the head word; the next word appears after the edge.
//   - A word written to an empty FIFO is visible the cycle after the write edge.
//   Write-to-read:
//   - Written data is readable no earlier than the cycle after its write edge.
//   - No same-cycle bypass.
// TESTING (DEPTH=8, DATA_W=32, AF=6, AE=2)
//   1. Reset, then write 1..8 on consecutive cycles
//      -> count 1..8; almost_full at count 6; full=1 after 8th write; empty=0.
//   2. FWFT=0: read 8 times -> rd_data 1..8, each 1 cycle after rd_en;
//      empty=1 after the last read; almost_empty at count 2.
//   3. Wrap: write 5, read 5, write 8, read 8 -> data order preserved across pointer wrap; no error flags.
//   4. Full + wr_en&rd_en -> read accepted, count 7, overflow=1;
//      empty + wr_en&rd_en -> count 1, underflow=1; clr_err -> both 0.
//   5. FWFT=1: write 0xA5 into empty -> rd_data=0xA5, rd_valid=1 next cycle
//      without rd_en; pop -> rd_valid=0.
//   6. Reset asserted with count=5 -> next cycle count=0, empty=1, rd_valid=0;
//      wr_en on reset cycle is ignored.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and sync_fifo_param (slave).
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: registered or first-word-fall-through read,
// occupancy count, threshold flags and sticky overflow/underflow errors.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  // Status decode and request acceptance, all from pre-edge state.
  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = (count_q == {CW{1'b0}});
    wr_acc = f.wr_en & ~full;
    rd_acc = f.rd_en & ~empty;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new error outranks a coincident clear.
    overflow_d  = (f.wr_en & full)  | (overflow_q  & ~f.clr_err);
    underflow_d = (f.rd_en & empty) | (underflow_q & ~f.clr_err);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset, but a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_acc & ~rst) begin
      mem[wr_ptr_q] <= f.wr_data;
    end
  end

  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = (count_q >= AF_C);
  assign f.almost_empty = (count_q <= AE_C);
  assign f.count        = count_q;
  assign f.overflow     = overflow_q;
  assign f.underflow    = underflow_q;

  if (FWFT != 0) begin : g_fwft
    assign f.rd_data  = mem[rd_ptr_q];
    assign f.rd_valid = ~empty;
  end else begin : g_reg_read
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // Registered read: data captured on an accepted pop, held otherwise.
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_acc) begin
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
      end
    end

    // Read output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= {DATA_W{1'b0}};
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign f.rd_data  = rd_data_q;
    assign f.rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives identical traffic into a registered-read and an FWFT FIFO and checks both
// against a queue-based reference model.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b0;

  sync_fifo_param_if #(.DATA_W(32), .DEPTH(8)) i0 ();
  sync_fifo_param_if #(.DATA_W(32), .DEPTH(8)) i1 ();

  sync_fifo_param #(.DATA_W(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0))
    u_reg (.clk(clk), .rst(rst), .f(i0));
  sync_fifo_param #(.DATA_W(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .f(i1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  logic [31:0] q [$];
  bit          ovf_m = 1'b0;
  bit          udf_m = 1'b0;
  bit          rdv0_m = 1'b0;
  logic [31:0] rd0_m = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_reg",  32'(i0.count), 32'(n));
    chk("count_fwft", 32'(i1.count), 32'(n));
    chk("empty_reg",  32'(i0.empty), 32'(n == 0));
    chk("empty_fwft", 32'(i1.empty), 32'(n == 0));
    chk("full_reg",   32'(i0.full),  32'(n == 8));
    chk("full_fwft",  32'(i1.full),  32'(n == 8));
    chk("afull_reg",  32'(i0.almost_full),  32'(n >= 6));
    chk("afull_fwft", 32'(i1.almost_full),  32'(n >= 6));
    chk("aempty_reg", 32'(i0.almost_empty), 32'(n <= 2));
    chk("aempty_fwft",32'(i1.almost_empty), 32'(n <= 2));
    chk("ovf_reg",    32'(i0.overflow),  32'(ovf_m));
    chk("ovf_fwft",   32'(i1.overflow),  32'(ovf_m));
    chk("udf_reg",    32'(i0.underflow), 32'(udf_m));
    chk("udf_fwft",   32'(i1.underflow), 32'(udf_m));
    chk("rdvalid_reg", 32'(i0.rd_valid), 32'(rdv0_m));
    chk("rddata_reg",  i0.rd_data, rd0_m);
    chk("rdvalid_fwft", 32'(i1.rd_valid), 32'(n != 0));
    if (n != 0) begin
      chk("rddata_fwft", i1.rd_data, q[0]);
    end
  endtask

  // One clock of traffic: drive inputs, advance the model on the edge, then check.
  task automatic step(input bit r, input bit w, input logic [31:0] d,
                      input bit rd, input bit c);
    bit full_m, empty_m;
    rst = r;
    i0.wr_en = w;  i0.wr_data = d;  i0.rd_en = rd;  i0.clr_err = c;
    i1.wr_en = w;  i1.wr_data = d;  i1.rd_en = rd;  i1.clr_err = c;
    @(posedge clk);
    step_no++;
    full_m  = (q.size() == 8);
    empty_m = (q.size() == 0);
    if (r) begin
      q.delete();
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      rdv0_m = 1'b0;
      rd0_m  = 32'h0;
    end else begin
      if (rd && !empty_m) begin
        rd0_m  = q.pop_front();
        rdv0_m = 1'b1;
      end else begin
        rdv0_m = 1'b0;
      end
      if (w && !full_m) q.push_back(d);
      ovf_m = (w && full_m)  || (ovf_m && !c);
      udf_m = (rd && empty_m) || (udf_m && !c);
    end
    #1;
    check_all();
  endtask

  initial begin
    i0.wr_en = 1'b0; i0.wr_data = 32'h0; i0.rd_en = 1'b0; i0.clr_err = 1'b0;
    i1.wr_en = 1'b0; i1.wr_data = 32'h0; i1.rd_en = 1'b0; i1.clr_err = 1'b0;

    // Reset, then fill with 1..8
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset_empty", 32'(i0.empty), 32'd1);
    for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 32'(k), 1'b0, 1'b0);
    chk("t1_full", 32'(i0.full), 32'd1);

    // Drain: registered read returns 1..8
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("t2_order", i0.rd_data, 32'(k));
    end
    chk("t2_empty", 32'(i0.empty), 32'd1);

    // Pointer wrap
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_no_ovf", 32'(i0.overflow), 32'd0);

    // Full with simultaneous wr/rd, then empty with simultaneous wr/rd, then clear
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h99, 1'b1, 1'b0);
    chk("t4_count7", 32'(i0.count), 32'd7);
    chk("t4_ovf", 32'(i0.overflow), 32'd1);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
    chk("t4_count1", 32'(i0.count), 32'd1);
    chk("t4_udf", 32'(i0.underflow), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_clr", 32'({i0.overflow, i0.underflow}), 32'd0);
    // Clear coinciding with a new error: set wins
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("t4_setwins", 32'(i0.underflow), 32'd1);

    // FWFT fall-through of a single word
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hA5, 1'b0, 1'b0);
    chk("t5_fwft_data", i1.rd_data, 32'hA5);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_fwft_valid", 32'(i1.rd_valid), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_pop", 32'(i1.rd_valid), 32'd0);

    // Reset mid-operation with a write on the reset cycle
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 32'h400 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    chk("t6_count0", 32'(i0.count), 32'd0);
    chk("t6_rdvalid", 32'(i0.rd_valid), 32'd0);

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < 80; n++) begin
        bit w, rd, c, r;
        w  = ($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 30));
        rd = ($urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 75));
        c  = ($urandom_range(0, 99) < 6);
        r  = ($urandom_range(0, 199) == 0);
        step(r, w, $urandom, rd, c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
